pwm_gen_multi: RTL
==================

PWM_GEN_MULTI -- requirements
Module: pwm_gen_multi

Parameters
REQ-001 The block SHALL provide parameter CNT_W, default 4, giving the period counter and duty width; the PWM period is 2^CNT_W clk cycles.
REQ-002 The block SHALL provide parameter CH, default 2, giving the number of independent PWM channels.
REQ-003 The block SHALL provide parameter DIV_W, default 22, giving the slow-enable divider width; slow_en asserts once every 2^DIV_W clk cycles.
REQ-004 The block SHALL provide parameter STEP, default 1, giving the duty increment or decrement applied per debounced press.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port inc, input, CH bits: raw, undebounced increase button per channel.
REQ-008 The block SHALL have port dec, input, CH bits: raw, undebounced decrease button per channel.
REQ-009 The block SHALL have port pwm_out, output, CH bits: registered PWM waveform per channel.
REQ-010 The block SHALL have port duty, output, CH*CNT_W bits: the requested duty per channel; channel c occupies bits [c*CNT_W +: CNT_W].

Function
REQ-011 The divider SHALL free-run from 0, wrap at all-ones, and assert internal slow_en for exactly one clk while it equals all-ones.
REQ-012 On slow_en, each raw inc and dec bit SHALL shift into a 3-stage enable-gated sampler: s0<=raw, s1<=s0, s2<=s1; the sampler SHALL hold between slow_en pulses.
REQ-013 A press pulse SHALL assert for exactly one clk, in the cycle after a slow_en update that leaves s0=1, s1=1, s2=0; a button held indefinitely SHALL yield exactly one pulse.
REQ-014 An input that is high for fewer than two consecutive slow_en samples SHALL produce no pulse.
REQ-015 On an inc pulse alone, the requested duty SHALL become min(duty+STEP, 2^CNT_W-1), with the saturation computed without overflow.
REQ-016 On a dec pulse alone, the requested duty SHALL become max(duty-STEP, 0), with the saturation computed without underflow.
REQ-017 When inc and dec pulses coincide on the same channel in the same cycle, the duty SHALL be unchanged.
REQ-018 The requested duty SHALL update one clk after its press pulse, and the duty output SHALL show it immediately.
REQ-019 A shared period counter pcnt SHALL free-run from 0 to 2^CNT_W-1 and wrap to 0.
REQ-020 Each channel SHALL keep an active duty, loaded from its requested duty only in the cycle where pcnt equals all-ones, so that a period is never truncated or glitched.
REQ-021 pwm_out[c] SHALL equal (pcnt < active_duty[c]) registered one clk later, giving a high time of exactly active_duty clk cycles per period.
REQ-022 Duty 0 SHALL give a constant low output, and duty 2^CNT_W-1 SHALL give one low cycle per period.
REQ-023 Channels SHALL be fully independent apart from the shared divider and pcnt.

Reset
REQ-024 While rst_n=0, the divider, pcnt, all sampler stages, press pulses and pwm_out SHALL be 0, independent of clk.
REQ-025 While rst_n=0, requested and active duty SHALL equal 2^(CNT_W-1), which is 8 for the defaults.
REQ-026 The first pcnt increment after rst_n deasserts SHALL occur on the first rising clk edge.
REQ-027 Reset asserted mid-period or mid-debounce SHALL discard all partial state with no pending update surviving.

Verification (CNT_W=4, CH=2, DIV_W=2, STEP=1)
REQ-028 Release reset with no presses -> both channels read duty 8, and each pwm_out is high 8 and low 8 of every 16 cycles, starting one clk after pcnt=0.
REQ-029 Hold inc[0] for 12 clk -> exactly one pulse, duty[3:0]=9, duty[7:4]=8, and ch0 is high 9 of 16 from the first full period after the update.
REQ-030 A 1-clk inc[1] glitch placed between slow_en pulses, then a glitch spanning only one sample -> no duty change.
REQ-031 Nine separate dec[0] presses -> duty 0, pwm_out[0] constantly 0, and further dec presses leave it at 0; then sixteen inc presses -> 15 with one low cycle per period.
REQ-032 inc[1] and dec[1] driven identically so their pulses coincide -> duty[7:4] stays 8.
REQ-033 Assert rst_n low mid-period with ch0 at duty 12 -> pwm_out=0 immediately without a clk edge, and after release duty is 8 again.

Source files
------------

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with per-channel debounced inc/dec buttons.
// A shared divider paces button sampling; a shared period counter drives every channel.
module pwm_gen_multi #(
  parameter int CNT_W = 4,
  parameter int CH    = 2,
  parameter int DIV_W = 22,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         inc,
  input  logic [CH-1:0]         dec,
  output logic [CH-1:0]         pwm_out,
  output logic [CH*CNT_W-1:0]   duty
);

  localparam logic [CNT_W-1:0] DUTY_MAX = '1;
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(STEP);

  logic [DIV_W-1:0] div_q;
  logic             slow_en;
  logic [CNT_W-1:0] pcnt_q;
  logic             pcnt_wrap;

  assign slow_en   = &div_q;
  assign pcnt_wrap = &pcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      pcnt_q <= '0;
    end else begin
      div_q  <= div_q + 1'b1;
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      // Sampler bit 0 is the newest sample (s0), bit 2 the oldest (s2).
      logic [2:0]       inc_s_q;
      logic [2:0]       dec_s_q;
      logic             inc_p_q;
      logic             dec_p_q;
      logic [CNT_W-1:0] duty_q;
      logic [CNT_W-1:0] duty_d;
      logic [CNT_W-1:0] act_q;
      logic             pwm_q;
      logic [CNT_W:0]   up_sum;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          inc_s_q <= '0;
          dec_s_q <= '0;
          inc_p_q <= 1'b0;
          dec_p_q <= 1'b0;
        end else if (slow_en) begin
          inc_s_q <= {inc_s_q[1:0], inc[gi]};
          dec_s_q <= {dec_s_q[1:0], dec[gi]};
          // Pulse when the post-shift pattern becomes s0=1, s1=1, s2=0.
          inc_p_q <= inc[gi] & inc_s_q[0] & ~inc_s_q[1];
          dec_p_q <= dec[gi] & dec_s_q[0] & ~dec_s_q[1];
        end else begin
          inc_p_q <= 1'b0;
          dec_p_q <= 1'b0;
        end
      end

      // Saturating arithmetic done one bit wider so the limits never wrap.
      assign up_sum = {1'b0, duty_q} + STEP_W;

      always_comb begin
        duty_d = duty_q;
        if (inc_p_q && !dec_p_q) begin
          duty_d = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[CNT_W-1:0];
        end else if (dec_p_q && !inc_p_q) begin
          duty_d = ({1'b0, duty_q} < STEP_W) ? '0 : duty_q - STEP_W[CNT_W-1:0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          duty_q <= DUTY_RST;
          act_q  <= DUTY_RST;
          pwm_q  <= 1'b0;
        end else begin
          duty_q <= duty_d;
          // Only adopt a new duty at the period boundary to avoid glitched periods.
          if (pcnt_wrap) begin
            act_q <= duty_q;
          end
          pwm_q <= (pcnt_q < act_q);
        end
      end

      assign pwm_out[gi]                = pwm_q;
      assign duty[gi*CNT_W +: CNT_W]    = duty_q;
    end
  endgenerate

endmodule
